bu2_intt_gs: RTL
================

Name: bu2_intt_gs

Overview:
- Pipelined Gentleman-Sande inverse butterfly for the inverse negacyclic NTT (INTT) datapath. It pairs with the forward Cooley-Tukey butterfly.
- Computes out_a = (in1 + in2) mod q and out_b = ((in1 - in2) * twiddle) mod q.
- Optional per-operation scaling by 2^-1 mod q folds the final n^-1 normalisation into the butterfly stages.
- Carries a valid/ready handshake with backpressure so the INTT stage controller can stall it. It forwards twiddle and modulus alongside the data, like the forward butterfly does.

Parameters:
- D_WIDTH, 32, width of coefficients, twiddles and modulus.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand set valid
- in_ready  out  1  block accepts the input this cycle
- in1  in  D_WIDTH  upper coefficient a, must be < modulus
- in2  in  D_WIDTH  lower coefficient b, must be < modulus
- twiddle  in  D_WIDTH  inverse twiddle w^-1, must be < modulus
- modulus  in  D_WIDTH  odd prime q, 3 <= q < 2^(D_WIDTH-1)
- half_en  in  1  scale both results by 2^-1 mod q
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- BU_a  out  D_WIDTH  sum result
- BU_b  out  D_WIDTH  twisted difference result
- twiddle_BU_out  out  D_WIDTH  twiddle aligned with the result
- modulus_BU_out  out  D_WIDTH  modulus aligned with the result

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pipeline registers, BU_a, BU_b, twiddle_BU_out, modulus_BU_out and out_valid go to 0.
  - in_ready reads 1 once out_valid is 0.
- Global advance: advance = !out_valid || out_ready; in_ready = advance (combinational).
  - All stages load only when advance = 1, otherwise every stage holds.
  - A transfer happens when in_valid && in_ready.
  - Stages with valid = 0 are bubbles and are overwritten freely.
- Stage 1, registered on accept:
  - sum = in1 + in2 computed in D_WIDTH+1 bits, minus q if >= q.
  - diff = in1 - in2 if in1 >= in2, else in1 - in2 + q.
  - twiddle, q, half_en and valid are captured alongside.
- Stage 2:
  - prod = diff * twiddle, full 2*D_WIDTH-bit product, registered.
  - sum and side-band fields are delayed one stage.
- Stage 3, output registers:
  - r = prod mod q, implemented as Barrett reduction; any bit-exact reduction is acceptable.
  - If half_en: halve(x) = x >> 1 when x is even, else (x + q) >> 1 in D_WIDTH+1 bits.
  - BU_a = half_en ? halve(sum) : sum; BU_b = half_en ? halve(r) : r.
  - twiddle_BU_out and modulus_BU_out are the values captured with the same operation.
- Latency and throughput:
  - Latency is exactly 3 cycles from accept to out_valid when unstalled.
  - Throughput is 1 operation per cycle.
- Results leave in acceptance order, with no loss or duplication under any out_ready pattern.
- While out_valid && !out_ready: outputs are stable and in_ready = 0.
- Simultaneous accept and drain in one cycle is legal: the full pipe streams.
- In-range inputs always give BU_a, BU_b < q. Out-of-range inputs give undefined results but must not corrupt neighbouring operations.
- Reset asserted mid-stream discards all in-flight operations. The first accepted operation after release appears 3 cycles later.

Test Plan:
- q=17, in1=5, in2=3, tw=4, half_en=0 -> 3 cycles later BU_a=8, BU_b=8, twiddle_BU_out=4, modulus_BU_out=17.
- q=17, in1=3, in2=5, tw=4, half_en=0 -> diff=15, BU_a=8, BU_b=9. Then in1=in2=16, half_en=1, tw=1 -> BU_a=16, BU_b=0.
- q=2^31-1, D_WIDTH=32:
  - in1=0, in2=1, tw=q-1 -> BU_a=1, BU_b=1.
  - in1=in2=q-1, tw=q-1 -> BU_a=q-2, BU_b=0.
- Stream 8 back-to-back ops with out_ready=0 from cycle 4 for 5 cycles:
  - in_ready drops and outputs hold.
  - After release, all 8 results appear in order, matching a reference model.
- Random out_ready (50%), random in_valid and random half_en over 10^4 ops with q=12289 -> every result matches the model, in order, with no drop or duplicate.
- Assert rst_n low with 3 ops in flight -> out_valid=0 and all outputs 0 immediately.
  - After release, a new op (q=17, 5, 3, 4) yields 8/8 after exactly 3 cycles.
  - No stale results appear.

Source files
------------

// File: rtl/bu2_intt_gs.sv
// Pipelined Gentleman-Sande inverse NTT butterfly.
//   BU_a = (in1 + in2) mod q
//   BU_b = ((in1 - in2) * twiddle) mod q
// Both results can be scaled by 2^-1 mod q.
// The pipe has three stages and a valid/ready handshake. A single global
// advance signal stalls every stage at once.
module bu2_intt_gs #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in1,
    input  logic [D_WIDTH-1:0] in2,
    input  logic [D_WIDTH-1:0] twiddle,
    input  logic [D_WIDTH-1:0] modulus,
    input  logic               half_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] BU_a,
    output logic [D_WIDTH-1:0] BU_b,
    output logic [D_WIDTH-1:0] twiddle_BU_out,
    output logic [D_WIDTH-1:0] modulus_BU_out
);

    localparam int W = D_WIDTH;

    // Halving mod q. An odd x becomes even when q (odd) is added.
    // The extra carry bit keeps the add exact before the shift.
    function automatic logic [W-1:0] halve(input logic [W-1:0] x, input logic [W-1:0] q);
        logic [W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
        return t[W:1];
    endfunction

    // The pipe moves when the output slot is empty or is being drained.
    // Bubbles move along with valid data, so no per-stage ready is needed.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1 registers
    logic         s1_valid;
    logic [W-1:0] s1_sum;
    logic [W-1:0] s1_diff;
    logic [W-1:0] s1_tw;
    logic [W-1:0] s1_q;
    logic         s1_half;

    // Stage 2 registers
    logic           s2_valid;
    logic [2*W-1:0] s2_prod;
    logic [W-1:0]   s2_sum;
    logic [W-1:0]   s2_tw;
    logic [W-1:0]   s2_q;
    logic           s2_half;

    // Stage 1 combinational: modular add and modular subtract
    logic [W:0]   sum_wide;
    logic [W:0]   sum_red;
    logic [W-1:0] diff;

    // Modular sum and difference of the incoming pair
    always_comb begin
        sum_wide = {1'b0, in1} + {1'b0, in2};
        sum_red  = sum_wide;
        if (sum_wide >= {1'b0, modulus}) begin
            sum_red = sum_wide - {1'b0, modulus};
        end
        diff = in1 - in2;
        if (in1 < in2) begin
            diff = in1 - in2 + modulus;
        end
    end

    // Stage 1 register: capture the sum, difference and side-band fields
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset along with the valid bits.
        // The outputs must read 0 during reset, not only out_valid.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_diff  <= '0;
            s1_tw    <= '0;
            s1_q     <= '0;
            s1_half  <= 1'b0;
        end else if (advance) begin
            // NOTE: non-blocking assignment, so every stage samples the
            // previous cycle's value of the stage before it.
            s1_valid <= in_valid;
            s1_sum   <= sum_red[W-1:0];
            s1_diff  <= diff;
            s1_tw    <= twiddle;
            s1_q     <= modulus;
            s1_half  <= half_en;
        end
    end

    // Stage 2 register: full-width product, side-band delayed one stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_sum   <= '0;
            s2_tw    <= '0;
            s2_q     <= '0;
            s2_half  <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_prod  <= s1_diff * s1_tw;
            s2_sum   <= s1_sum;
            s2_tw    <= s1_tw;
            s2_q     <= s1_q;
            s2_half  <= s1_half;
        end
    end

    // Stage 3 combinational: reduce the product and optionally halve.
    // q can change on every operation, so there is no precomputed Barrett
    // constant. A direct bit-exact modulo is used instead. A zero modulus
    // is out of range, and in that case the result is forced to 0.
    logic [2*W-1:0] prod_mod;
    logic [W-1:0]   res_a;
    logic [W-1:0]   res_b;

    // Product reduction and the optional 2^-1 scaling
    always_comb begin
        prod_mod = '0;
        if (s2_q != '0) begin
            prod_mod = s2_prod % {{W{1'b0}}, s2_q};
        end
        res_a = s2_sum;
        res_b = prod_mod[W-1:0];
        if (s2_half) begin
            res_a = halve(s2_sum, s2_q);
            res_b = halve(prod_mod[W-1:0], s2_q);
        end
    end

    // Output register: holds while stalled, so outputs stay stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            BU_a           <= '0;
            BU_b           <= '0;
            twiddle_BU_out <= '0;
            modulus_BU_out <= '0;
        end else if (advance) begin
            out_valid      <= s2_valid;
            BU_a           <= res_a;
            BU_b           <= res_b;
            twiddle_BU_out <= s2_tw;
            modulus_BU_out <= s2_q;
        end
    end

endmodule
